// File: rtl/impuls_pkg.sv
// Shared types, default sizing and helpers for the impulse stretcher slice.
package impuls_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int unsigned DEF_CHANNELS  = 4;
  localparam int unsigned DEF_OUT_WIDTH = 16;
  localparam int unsigned DEF_HOLD_W    = 4;
  localparam int unsigned DEF_EVT_W     = 8;

  // A programmed hold of zero ticks is treated as one tick.
  function automatic logic [31:0] hold_clamp(input logic [31:0] hold_ms);
    return (hold_ms == 32'd0) ? 32'd1 : hold_ms;
  endfunction

endpackage

// File: rtl/impuls_channel.sv
// One impulse channel: 2-flop synchroniser, rising-edge detect, hold FSM and event counter.
module impuls_channel
  import impuls_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned HOLD_W    = DEF_HOLD_W,
  parameter int unsigned EVT_W     = DEF_EVT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 impuls,
  input  logic                 tick,
  input  logic [HOLD_W-1:0]    hold_ms,
  input  logic                 retrig,
  output logic [OUT_WIDTH-1:0] imp,
  output logic                 active,
  output logic [EVT_W-1:0]     evt_cnt
);

  state_t            state, state_d;
  logic [HOLD_W-1:0] cnt, cnt_d;
  logic [HOLD_W-1:0] hold_lat, hold_lat_d;
  logic [EVT_W-1:0]  evt_d;
  logic              s_meta, s, s_q;
  logic              trig;

  assign trig = s & ~s_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s_meta   <= 1'b0;
      s        <= 1'b0;
      s_q      <= 1'b0;
      state    <= ST_IDLE;
      cnt      <= '0;
      hold_lat <= '0;
      evt_cnt  <= '0;
      active   <= 1'b0;
      imp      <= '0;
    end else begin
      s_meta   <= impuls;
      s        <= s_meta;
      s_q      <= s;
      state    <= state_d;
      cnt      <= cnt_d;
      hold_lat <= hold_lat_d;
      evt_cnt  <= evt_d;
      active   <= (state_d == ST_HOLD);
      imp      <= (state_d == ST_HOLD) ? '1 : '0;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    hold_lat_d = hold_lat;
    evt_d      = evt_cnt;
    unique case (state)
      ST_IDLE: begin
        if (trig) begin
          state_d    = ST_HOLD;
          cnt_d      = '0;
          hold_lat_d = HOLD_W'(hold_clamp(32'(hold_ms)));
          evt_d      = evt_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        // A retrigger restarts the hold and swallows a coincident tick.
        if (trig && retrig) begin
          cnt_d      = '0;
          hold_lat_d = HOLD_W'(hold_clamp(32'(hold_ms)));
          evt_d      = evt_cnt + 1'b1;
        end else if (tick) begin
          if (cnt + 1'b1 == hold_lat) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/impuls_stretch.sv
// Multi-channel pulse stretcher: shared millisecond tick plus independent stretch channels.
module impuls_stretch
  import impuls_pkg::*;
#(
  parameter int unsigned CHANNELS  = DEF_CHANNELS,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned HOLD_W    = DEF_HOLD_W,
  parameter int unsigned EVT_W     = DEF_EVT_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          msec,
  input  logic [CHANNELS-1:0]           impuls,
  input  logic [HOLD_W-1:0]             hold_ms,
  input  logic [CHANNELS-1:0]           retrig,
  output logic [CHANNELS*OUT_WIDTH-1:0] imp,
  output logic [CHANNELS-1:0]           active,
  output logic [CHANNELS*EVT_W-1:0]     evt_cnt
);

  logic msec_q;
  logic tick;

  // tick is the registered msec rising edge, so it is high the cycle after
  // msec is first sampled high, regardless of the msec high time.
  always_ff @(posedge clock) begin
    if (reset) begin
      msec_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      msec_q <= msec;
      tick   <= msec & ~msec_q;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    impuls_channel #(
      .OUT_WIDTH (OUT_WIDTH),
      .HOLD_W    (HOLD_W),
      .EVT_W     (EVT_W)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .impuls  (impuls[k]),
      .tick    (tick),
      .hold_ms (hold_ms),
      .retrig  (retrig[k]),
      .imp     (imp[k*OUT_WIDTH +: OUT_WIDTH]),
      .active  (active[k]),
      .evt_cnt (evt_cnt[k*EVT_W +: EVT_W])
    );
  end

endmodule

// File: tb/tb_impuls_stretch.sv
// Self-checking bench for impuls_stretch: directed scenarios plus randomized traffic against a tick/trigger model.
module tb_impuls_stretch;

  localparam int unsigned CH = 4;
  localparam int unsigned OW = 16;
  localparam int unsigned HW = 4;
  localparam int unsigned EW = 8;
  localparam int unsigned P  = 20;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              msec = 1'b0;
  logic [CH-1:0]     impuls = '0;
  logic [HW-1:0]     hold_ms = 4'd11;
  logic [CH-1:0]     retrig = '0;
  logic [CH*OW-1:0]  imp;
  logic [CH-1:0]     active;
  logic [CH*EW-1:0]  evt_cnt;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned phase = 0;
  int unsigned msec_hi = 3;

  impuls_stretch #(
    .CHANNELS  (CH),
    .OUT_WIDTH (OW),
    .HOLD_W    (HW),
    .EVT_W     (EW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .msec    (msec),
    .impuls  (impuls),
    .hold_ms (hold_ms),
    .retrig  (retrig),
    .imp     (imp),
    .active  (active),
    .evt_cnt (evt_cnt)
  );

  always #5 clock = ~clock;

  // Model: input history seen at each edge, remaining ticks per channel.
  logic [CH-1:0]    h0 = '0, h1 = '0, h2 = '0;
  logic             mq0 = 1'b0, mq1 = 1'b0;
  bit               m_hold [CH];
  int unsigned      m_left [CH];
  int unsigned      m_evt  [CH];
  int unsigned      trig_tick [CH];
  int unsigned      tick_count = 0;
  logic [CH*OW-1:0] m_imp = '0;
  logic [CH-1:0]    m_act = '0;
  logic [CH*EW-1:0] m_evtv = '0;

  initial begin
    for (int k = 0; k < CH; k++) begin
      m_hold[k] = 0; m_left[k] = 0; m_evt[k] = 0; trig_tick[k] = 0;
    end
    forever begin
      @(posedge clock);
      if (reset) begin
        for (int k = 0; k < CH; k++) begin
          m_hold[k] = 0; m_left[k] = 0; m_evt[k] = 0;
        end
        h0 = '0; h1 = '0; h2 = '0; mq0 = 1'b0; mq1 = 1'b0;
      end else begin
        bit tk;
        int unsigned lat;
        tk  = mq0 && !mq1;
        lat = (hold_ms == 0) ? 1 : int'(hold_ms);
        if (tk) tick_count++;
        for (int k = 0; k < CH; k++) begin
          bit trg;
          trg = h1[k] && !h2[k];
          if (!m_hold[k]) begin
            if (trg) begin
              m_hold[k] = 1; m_left[k] = lat; m_evt[k]++; trig_tick[k] = tick_count;
            end
          end else if (trg && retrig[k]) begin
            m_left[k] = lat; m_evt[k]++; trig_tick[k] = tick_count;
          end else if (tk) begin
            m_left[k]--;
            if (m_left[k] == 0) m_hold[k] = 0;
          end
        end
        h2 = h1; h1 = h0; h0 = impuls; mq1 = mq0; mq0 = msec;
      end
      for (int k = 0; k < CH; k++) begin
        m_imp[k*OW +: OW] = m_hold[k] ? '1 : '0;
        m_act[k]          = m_hold[k];
        m_evtv[k*EW +: EW] = EW'(m_evt[k] % 256);
      end
    end
  end

  task automatic cycle();
    @(negedge clock);
    phase = (phase + 1) % P;
    msec  = (phase < msec_hi);
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_idle(input int unsigned ch, output bit ok);
    ok = 0;
    for (int unsigned i = 0; i < 2000; i++) begin
      cycle();
      if (imp[ch*OW +: OW] == '0) begin ok = 1; break; end
    end
  endtask

  task automatic wait_ticks(input int unsigned n);
    int unsigned start;
    start = tick_count;
    for (int unsigned i = 0; i < 2000 && tick_count - start < n; i++) cycle();
  endtask

  task automatic pulse(input int unsigned ch, input int unsigned len);
    impuls[ch] = 1'b1;
    cycles(len);
    impuls[ch] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycles(3);
    checks++;
    if ({imp, active, evt_cnt} !== '0) $display("FAIL reset_state got imp=%h act=%b evt=%h want all zero", imp, active, evt_cnt);
    else passes++;
    reset = 1'b0;
    cycles(2);
    checks++;
    if ({imp, active, evt_cnt} !== {m_imp, m_act, m_evtv}) $display("FAIL reset_model got %h/%b/%h want %h/%b/%h", imp, active, evt_cnt, m_imp, m_act, m_evtv);
    else passes++;
  endtask

  task automatic test_basic();
    bit ok;
    hold_ms = 4'd11;
    impuls[0] = 1'b1;
    cycles(2);
    checks++;
    if (imp[15:0] !== 16'h0000) $display("FAIL basic_latency2 got %h want 0000", imp[15:0]);
    else passes++;
    cycle();
    checks++;
    if (imp[15:0] !== 16'hFFFF || active[0] !== 1'b1) $display("FAIL basic_latency3 got %h act=%b want FFFF act=1", imp[15:0], active[0]);
    else passes++;
    cycles(2);
    impuls[0] = 1'b0;
    wait_idle(0, ok);
    checks++;
    if (!ok || tick_count - trig_tick[0] != 11) $display("FAIL basic_hold got ok=%0d ticks=%0d want 11", ok, tick_count - trig_tick[0]);
    else passes++;
    checks++;
    if (evt_cnt[7:0] !== 8'd1 || imp[CH*OW-1:OW] !== '0 || active !== '0) $display("FAIL basic_evt got evt=%h imp=%h act=%b want evt=01 others 0", evt_cnt[7:0], imp, active);
    else passes++;
  endtask

  task automatic test_edge_only();
    bit ok;
    retrig[1] = 1'b0;
    impuls[1] = 1'b1;
    wait_ticks(30);
    checks++;
    if (imp[31:16] !== 16'h0 || evt_cnt[15:8] !== 8'd1) $display("FAIL edge_level got imp=%h evt=%h want 0000 evt=01", imp[31:16], evt_cnt[15:8]);
    else passes++;
    impuls[1] = 1'b0;
    cycles(4);
    pulse(1, 3);
    cycles(20);
    pulse(1, 3);
    cycles(10);
    checks++;
    if (active[1] !== 1'b1 || evt_cnt[15:8] !== 8'd2) $display("FAIL edge_ignored_retrig got act=%b evt=%h want act=1 evt=02", active[1], evt_cnt[15:8]);
    else passes++;
    wait_idle(1, ok);
    checks++;
    if (!ok || {imp, active, evt_cnt} !== {m_imp, m_act, m_evtv}) $display("FAIL edge_model got %h/%b/%h want %h/%b/%h", imp, active, evt_cnt, m_imp, m_act, m_evtv);
    else passes++;
  endtask

  task automatic test_retrig();
    bit ok;
    int unsigned guard;
    retrig[2] = 1'b1;
    hold_ms = 4'd11;
    pulse(2, 5);
    guard = 0;
    while (!(tick_count - trig_tick[2] == 7 && phase == P - 1) && guard < 3000) begin
      cycle();
      guard++;
    end
    impuls[2] = 1'b1;
    cycles(2);
    checks++;
    if (evt_cnt[23:16] !== 8'd1) $display("FAIL retrig_pre got evt=%h want 01", evt_cnt[23:16]);
    else passes++;
    cycle();
    impuls[2] = 1'b0;
    checks++;
    if (evt_cnt[23:16] !== 8'd2 || imp[47:32] !== 16'hFFFF) $display("FAIL retrig_evt got evt=%h imp=%h want 02 FFFF", evt_cnt[23:16], imp[47:32]);
    else passes++;
    wait_idle(2, ok);
    checks++;
    if (!ok || tick_count - trig_tick[2] != 11) $display("FAIL retrig_hold got ok=%0d ticks=%0d want 11", ok, tick_count - trig_tick[2]);
    else passes++;
  endtask

  task automatic test_hold_bounds();
    bit ok;
    hold_ms = 4'd0;
    pulse(0, 3);
    wait_idle(0, ok);
    checks++;
    if (!ok || tick_count - trig_tick[0] != 1) $display("FAIL hold_zero got ok=%0d ticks=%0d want 1", ok, tick_count - trig_tick[0]);
    else passes++;
    cycles(3);
    hold_ms = 4'd15;
    pulse(0, 3);
    wait_idle(0, ok);
    checks++;
    if (!ok || tick_count - trig_tick[0] != 15) $display("FAIL hold_max got ok=%0d ticks=%0d want 15", ok, tick_count - trig_tick[0]);
    else passes++;
    pulse(0, 3);
    wait_ticks(3);
    hold_ms = 4'd2;
    wait_idle(0, ok);
    checks++;
    if (!ok || tick_count - trig_tick[0] != 15) $display("FAIL hold_change got ok=%0d ticks=%0d want 15", ok, tick_count - trig_tick[0]);
    else passes++;
  endtask

  task automatic test_reset_wrap();
    hold_ms = 4'd11;
    pulse(0, 3);
    wait_ticks(5);
    reset = 1'b1;
    cycle();
    checks++;
    if ({imp, active, evt_cnt} !== '0) $display("FAIL reset_hold got imp=%h act=%b evt=%h want all zero", imp, active, evt_cnt);
    else passes++;
    reset = 1'b0;
    cycles(3);
    hold_ms = 4'd1;
    retrig[3] = 1'b1;
    for (int unsigned i = 0; i < 256; i++) begin
      pulse(3, 2);
      cycles(2);
      if (i == 254) begin
        cycles(3);
        checks++;
        if (evt_cnt[31:24] !== 8'd255) $display("FAIL wrap_255 got evt=%h want ff", evt_cnt[31:24]);
        else passes++;
      end
    end
    cycles(4);
    checks++;
    if (evt_cnt[31:24] !== 8'd0 || {imp, active, evt_cnt} !== {m_imp, m_act, m_evtv}) $display("FAIL wrap_256 got evt=%h want 00 (model %h)", evt_cnt[31:24], m_evtv);
    else passes++;
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        retrig  = CH'($urandom);
        hold_ms = HW'($urandom_range(0, 4));
        msec_hi = $urandom_range(1, 6);
      end
      reset = ($urandom_range(0, 1499) == 0);
      for (int k = 0; k < CH; k++)
        if ($urandom_range(0, 29) == 0) impuls[k] = ~impuls[k];
      cycle();
      checks++;
      if ({imp, active, evt_cnt} !== {m_imp, m_act, m_evtv}) $display("FAIL random_c%0d got %h/%b/%h want %h/%b/%h", i, imp, active, evt_cnt, m_imp, m_act, m_evtv);
      else passes++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_only();
    test_retrig();
    test_hold_bounds();
    test_reset_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
